sdm2_tx: RTL and testbench

- Second-order sigma-delta transmitter.
- Accepts signed PCM samples through a toggle-push / empty handshake and emits a 1-bit density-modulated stream, one bit per rising edge of the asynchronous bit clock fclk.
- Sits beside sdm_rx as the higher-SNR transmit end of the same 1-wire sdm link; its tx output drives the rx input directly.

---
 rtl/sdm_pkg.sv | 34 +++
 rtl/sdm_sync_edge.sv | 28 ++
 rtl/sdm2_tx.sv | 173 +++++++++++++++++
 tb/tb_sdm2_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sdm_pkg.sv
// Shared types, constants and helpers for the sdm link (sdm2_tx / sdm_rx).
// Default geometry: 4-bit samples, OSR 8, 9-bit saturating integrators.
package sdm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } sdm_state_e;

  localparam int SDM_DMSB = 3;
  localparam int SDM_CMSB = 2;
  localparam int SDM_BMSB = 3;

  localparam int FS  = 1 << SDM_DMSB;
  localparam int OSR = 1 << (SDM_CMSB + 1);
  localparam int IW  = SDM_DMSB + SDM_BMSB + 3;

  // Galois form of x^16+x^14+x^13+x^11+1, right-shifting
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // clamp v to the two's-complement range of an (msb+1)-bit signed value
  function automatic int sat(input int v, input int msb);
    int hi;
    int lo;
    hi = (1 << msb) - 1;
    lo = -(1 << msb);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sdm_sync_edge.sv
// Two-flop synchronizer for an asynchronous clock-like input, plus a
// one-cycle pulse on each synchronized rising edge.
module sdm_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/sdm2_tx.sv
// Second-order sigma-delta transmitter: toggle-push sample input, 1-bit
// stream out, one bit per fclk rise. Define SDM2_TX_DITHER_EN for LFSR dither.
//
// state | meaning
// IDLE  | tx=0, integrators zero, waiting for a sample and a tick
// RUN   | modulating; new sample loaded each time cst wraps to 0
// DRAIN | input forced 0, buffer flushed, OSR more ticks then IDLE
module sdm2_tx
  import sdm_pkg::*;
#(
  parameter int DMSB = SDM_DMSB,
  parameter int CMSB = SDM_CMSB,
  parameter int BMSB = SDM_BMSB
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               setn,
  input  logic               fclk,
  input  logic               push,
  input  logic               clear,
  input  logic signed [DMSB:0] wdata,
  output logic               empty,
  output logic               tx,
  output logic [1:0]         xst,
  output logic [1:0]         nst,
  output logic [CMSB:0]      cst
);

  localparam int FULL = 1 << DMSB;
  localparam int IWM  = DMSB + BMSB + 3;

  sdm_state_e              xst_q;
  sdm_state_e              nst_c;
  logic                    tick;
  logic [CMSB:0]           cst_q;
  logic [CMSB:0]           dct_q;
  logic signed [IWM-1:0]   i1_q;
  logic signed [IWM-1:0]   i2_q;
  logic signed [DMSB:0]    hold_q;
  logic signed [DMSB:0]    act_q;
  logic signed [DMSB:0]    x_cur;
  logic                    empty_q;
  logic                    tx_q;
  logic                    push_d;
  logic                    write;
  logic                    enter_run;
  logic                    mod_en;
  logic                    load;
  int                      fb;
  int                      dith;
  int                      s1;
  int                      s2;

  sdm_sync_edge u_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (fclk),
    .pulse (tick)
  );

`ifdef SDM2_TX_DITHER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (tick) begin
      lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_POLY) : (lfsr_q >> 1);
    end
  end
`endif

  always_comb begin
    nst_c = xst_q;
    if (!setn) begin
      nst_c = IDLE;
    end else begin
      case (xst_q)
        IDLE:    if (!clear && !empty_q && tick) nst_c = RUN;
        RUN:     if (clear) nst_c = DRAIN;
        DRAIN:   if (tick && dct_q == '0) nst_c = IDLE;
        default: nst_c = IDLE;
      endcase
    end
  end

  // the IDLE->RUN tick behaves as the cst==0 tick of the first sample period
  assign write     = push ^ push_d;
  assign enter_run = (xst_q == IDLE) && (nst_c == RUN);
  assign mod_en    = tick && (xst_q == RUN || xst_q == DRAIN || enter_run);
  assign load      = tick && ((xst_q == RUN && cst_q == '0) || enter_run);

  always_comb begin
    x_cur = act_q;
    if (xst_q == DRAIN) begin
      x_cur = '0;
    end else if (load && !empty_q) begin
      x_cur = hold_q;
    end
    fb   = tx_q ? FULL : -FULL;
    dith = 0;
`ifdef SDM2_TX_DITHER_EN
    dith = lfsr_q[0] ? 1 : -1;
`endif
    s1 = sat(int'(i1_q) + int'(x_cur) - fb + dith, IWM - 1);
    s2 = sat(int'(i2_q) + s1 - fb, IWM - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xst_q   <= IDLE;
      cst_q   <= '0;
      dct_q   <= '0;
      i1_q    <= '0;
      i2_q    <= '0;
      tx_q    <= 1'b0;
      hold_q  <= '0;
      act_q   <= '0;
      empty_q <= 1'b1;
      push_d  <= push;
    end else begin
      push_d <= push;
      xst_q  <= nst_c;
      if (!setn) begin
        cst_q   <= '0;
        i1_q    <= '0;
        i2_q    <= '0;
        tx_q    <= 1'b0;
        hold_q  <= '0;
        act_q   <= '0;
        empty_q <= 1'b1;
      end else begin
        if (mod_en) begin
          i1_q  <= s1[IWM-1:0];
          i2_q  <= s2[IWM-1:0];
          tx_q  <= (s2 >= 0);
          cst_q <= cst_q + 1'b1;
        end
        if (load) begin
          act_q   <= empty_q ? act_q : hold_q;
          empty_q <= 1'b1;
        end
        if (write) begin
          hold_q  <= wdata;
          empty_q <= 1'b0;
        end
        // flush beats a simultaneous write
        if (clear || xst_q == DRAIN) begin
          hold_q  <= '0;
          empty_q <= 1'b1;
        end
        if (xst_q == RUN && nst_c == DRAIN) begin
          dct_q <= '1;
        end else if (xst_q == DRAIN && tick) begin
          dct_q <= dct_q - 1'b1;
        end
        if (nst_c == IDLE) begin
          i1_q  <= '0;
          i2_q  <= '0;
          tx_q  <= 1'b0;
          cst_q <= '0;
        end
      end
    end
  end

  assign empty = empty_q;
  assign tx    = tx_q;
  assign xst   = xst_q;
  assign nst   = nst_c;
  assign cst   = cst_q;

endmodule

// File: tb/tb_sdm2_tx.sv
// Directed bench for sdm2_tx: reset, density over 256 bits, buffer
// overwrite/underrun, load/push collision, drain and disable.
module tb_sdm2_tx;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              setn = 1'b0;
  logic              fclk = 1'b0;
  logic              push = 1'b0;
  logic              clear = 1'b0;
  logic signed [3:0] wdata = '0;
  logic              empty;
  logic              tx;
  logic [1:0]        xst;
  logic [1:0]        nst;
  logic [2:0]        cst;

  int n_chk = 0;
  int n_err = 0;
  int ones;

`ifdef SDM2_TX_DITHER_EN
  localparam int TOL = 4;
`else
  localparam int TOL = 2;
`endif

  sdm2_tx dut (
    .clk   (clk),
    .rst   (rst),
    .setn  (setn),
    .fclk  (fclk),
    .push  (push),
    .clear (clear),
    .wdata (wdata),
    .empty (empty),
    .tx    (tx),
    .xst   (xst),
    .nst   (nst),
    .cst   (cst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_push(input logic signed [3:0] v);
    @(negedge clk);
    wdata = v;
    push  = ~push;
  endtask

  // one fclk period of 16 clk; the tick lands 3 clk after the rise
  task automatic fclk_tick();
    @(negedge clk);
    fclk = 1'b1;
    repeat (8) @(negedge clk);
    fclk = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // push toggled so that it is sampled on the same clk as the tick
  task automatic tick_push(input logic signed [3:0] v);
    @(negedge clk);
    fclk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wdata = v;
    push  = ~push;
    repeat (6) @(negedge clk);
    fclk = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic restart();
    @(negedge clk);
    rst   = 1'b1;
    clear = 1'b0;
    @(negedge clk);
    rst  = 1'b0;
    setn = 1'b1;
  endtask

  task automatic run_ones(input int n, input logic signed [3:0] v, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (i % 8 == 4) do_push(v);
      fclk_tick();
      if (tx) cnt++;
    end
  endtask

  initial begin
    // reset with fclk toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      fclk = ~fclk;
      chk("rst_empty", int'(empty), 1);
      chk("rst_tx", int'(tx), 0);
      chk("rst_xst", int'(xst), 0);
      chk("rst_cst", int'(cst), 0);
    end
    @(negedge clk);
    rst  = 1'b0;
    fclk = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_empty", int'(empty), 1);
    chk("post_rst_xst", int'(xst), 0);

    // density: zero, +half scale, -half scale
    setn = 1'b1;
    do_push(4'sd0);
    @(negedge clk);
    chk("push_empty_fall", int'(empty), 0);
    run_ones(256, 4'sd0, ones);
    chk("ones_zero", (ones >= 128 - TOL && ones <= 128 + TOL) ? 128 : ones, 128);

    restart();
    do_push(4'sd4);
    run_ones(256, 4'sd4, ones);
    chk("ones_pos4", (ones >= 192 - TOL && ones <= 192 + TOL) ? 192 : ones, 192);

    restart();
    do_push(-4'sd4);
    run_ones(256, -4'sd4, ones);
    chk("ones_neg4", (ones >= 64 - TOL && ones <= 64 + TOL) ? 64 : ones, 64);

    // overwrite while occupied: latest value is the one loaded
    restart();
    do_push(4'sd1);
    fclk_tick();
    chk("enter_xst", int'(xst), 1);
    chk("enter_cst", int'(cst), 1);
    chk("enter_empty", int'(empty), 1);
    do_push(4'sd3);
    do_push(4'sd5);
    @(negedge clk);
    chk("ovw_hold", int'(dut.hold_q), 5);
    chk("ovw_empty", int'(empty), 0);
    repeat (7) fclk_tick();
    chk("preload_cst", int'(cst), 0);
    chk("preload_empty", int'(empty), 0);
    fclk_tick();
    chk("load_act", int'(dut.act_q), 5);
    chk("load_empty", int'(empty), 1);
    chk("load_cst", int'(cst), 1);

    // push coincident with load, then underrun
    do_push(4'sd2);
    repeat (7) fclk_tick();
    chk("coin_pre_cst", int'(cst), 0);
    tick_push(4'sd6);
    chk("coin_act", int'(dut.act_q), 2);
    chk("coin_hold", int'(dut.hold_q), 6);
    chk("coin_empty", int'(empty), 0);
    repeat (16) fclk_tick();
    chk("under_act", int'(dut.act_q), 6);
    chk("under_empty", int'(empty), 1);
    chk("under_xst", int'(xst), 1);
    chk("under_cst", int'(cst), 1);

    // clear in RUN -> DRAIN for exactly 8 ticks
    @(negedge clk);
    clear = 1'b1;
    #1;
    chk("clr_nst", int'(nst), 2);
    @(negedge clk);
    chk("drain_xst", int'(xst), 2);
    chk("drain_empty", int'(empty), 1);
    clear = 1'b0;
    repeat (7) fclk_tick();
    chk("drain7_xst", int'(xst), 2);
    fclk_tick();
    chk("drain8_xst", int'(xst), 0);
    chk("drain8_tx", int'(tx), 0);
    chk("drain8_cst", int'(cst), 0);

    // setn low mid-RUN
    do_push(4'sd4);
    fclk_tick();
    chk("rerun_xst", int'(xst), 1);
    repeat (2) fclk_tick();
    @(negedge clk);
    setn = 1'b0;
    #1;
    chk("setn_nst", int'(nst), 0);
    @(negedge clk);
    chk("setn_xst", int'(xst), 0);
    chk("setn_empty", int'(empty), 1);
    chk("setn_tx", int'(tx), 0);
    chk("setn_cst", int'(cst), 0);

    // clear in IDLE only flushes holding
    setn = 1'b1;
    do_push(4'sd3);
    @(negedge clk);
    chk("idle_full", int'(empty), 0);
    clear = 1'b1;
    @(negedge clk);
    chk("idle_flush", int'(empty), 1);
    clear = 1'b0;
    fclk_tick();
    chk("idle_stay", int'(xst), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
